// File: rtl/adc_sample_scheduler.sv
// Round-robin scheduler for a two-requester serial ADC.
// Each access returns the previous conversion, so the first access after reset primes the ADC.
module adc_sample_scheduler #(
    parameter int SCLK_DIV    = 1,
    parameter int CS_SETUP    = 2,
    parameter int CONV_CYCLES = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic       done,
    output logic       done_id,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    input  logic       adc_sdo
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        CONVERT
    } state_t;

    localparam logic [15:0] SET_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] DIV_END = 16'(SCLK_DIV - 1);
    // The IDLE cycle before the next grant completes the conversion window.
    localparam logic [15:0] CONV_END =
        16'((CONV_CYCLES > 1) ? (CONV_CYCLES - 2) : 0);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        primed_q, primed_d;
    logic        again_q, again_d;
    logic        done_d;
    logic        done_id_d;
    logic [7:0]  rdata_d;
    logic        cs_n_d;
    logic        sclk_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        shreg_d   = shreg_q;
        grant_d   = grant_q;
        last_d    = last_q;
        primed_d  = primed_q;
        again_d   = again_q;
        done_d    = 1'b0;
        done_id_d = done_id;
        rdata_d   = rdata;
        unique case (state_q)
            IDLE: begin
                if (again_q) begin
                    again_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end else if (|req) begin
                    grant_d = (&req) ? ~last_q : req[1];
                    last_d  = grant_d;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == SET_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == DIV_END) begin
                    cnt_d = '0;
                    if (phase_q) begin
                        shreg_d = {shreg_q[6:0], adc_sdo};
                        phase_d = 1'b0;
                    end else if (bit_q == 3'd7) begin
                        state_d = CONVERT;
                        if (primed_q) begin
                            done_d    = 1'b1;
                            rdata_d   = shreg_q;
                            done_id_d = grant_q;
                        end else begin
                            primed_d = 1'b1;
                            again_d  = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        phase_d = 1'b1;
                    end
                end
            end
            CONVERT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= CONV_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cs_n_d = !((state_d == SETUP) || (state_d == SHIFT));
        sclk_d = (state_d == SHIFT) && phase_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            shreg_q  <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            primed_q <= 1'b0;
            again_q  <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            rdata    <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            shreg_q  <= shreg_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            primed_q <= primed_d;
            again_q  <= again_d;
            done     <= done_d;
            done_id  <= done_id_d;
            rdata    <= rdata_d;
            adc_cs_n <= cs_n_d;
            adc_sclk <= sclk_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
